// File: rtl/pc_stage_vec_pkg.sv
// Shared definitions for the vectored PC stage: mtvec mode encodings,
// default interrupt cause base, PC source selector and width helpers.
package pc_stage_vec_pkg;

  // mtvec MODE field encodings
  localparam logic MTVEC_DIRECT   = 1'b0;
  localparam logic MTVEC_VECTORED = 1'b1;

  // Cause code reported by interrupt source 0
  localparam int CAUSE_BASE_DEF = 16;

  // Where the next fetch PC comes from, in decreasing priority
  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_START = 3'd1,
    PC_IRQ   = 3'd2,
    PC_TRAP  = 3'd3,
    PC_MRET  = 3'd4,
    PC_SRET  = 3'd5,
    PC_JMP   = 3'd6,
    PC_SEQ   = 3'd7
  } pc_src_e;

  // Bits needed to hold every cause code cause_base .. cause_base+num_irq-1
  function automatic int cause_width(input int num_irq, input int cause_base);
    int top;
    top = cause_base + num_irq;
    return (top <= 2) ? 1 : $clog2(top);
  endfunction

  // Bits needed to hold a source index 0 .. n-1 (at least one bit)
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_stage_vec_irq_pend_prio.sv
// Interrupt front end: per-source rising-edge detect, pending latches and a
// fixed-priority (lowest index first) selector over the enabled pending set.
module irq_pend_prio
  import pc_stage_vec_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int SW      = idx_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               rmie,
  input  logic               take,
  output logic               any,
  output logic [SW-1:0]      sel,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] irq_d_r;
  logic [NUM_IRQ-1:0] pend_r;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] cand_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [SW-1:0]      sel_s;
  logic               found_s;

  // New edges only count while the source and global enable are both on
  assign rise_s = irq_in & ~irq_d_r & irq_en & {NUM_IRQ{rmie}};
  assign cand_s = pend_r & irq_en;

  // Lowest-index enabled pending source wins
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      sel_s   = (cand_s[i] && !found_s) ? SW'(i) : sel_s;
      found_s = found_s | cand_s[i];
    end
  end

  // Only the source actually taken loses its pending bit
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_s[i] = take && (sel_s == SW'(i));
    end
  end

  // Edge history and pending latches; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d_r <= '0;
      pend_r  <= '0;
    end else begin
      irq_d_r <= irq_in;
      pend_r  <= (pend_r & ~clr_s) | rise_s;
    end
  end

  assign any     = found_s;
  assign sel     = sel_s;
  assign pending = pend_r;

endmodule

// File: rtl/pc_stage_vec.sv
// Fetch PC generator with start load, EX-stage redirects, trap/return
// redirects, ecall/ebreak keepers and NUM_IRQ edge-triggered interrupts
// using direct or vectored mtvec targets.
module pc_stage_vec
  import pc_stage_vec_pkg::*;
#(
  parameter int NUM_IRQ    = 4,
  parameter int CAUSE_BASE = CAUSE_BASE_DEF,
  parameter int CW         = cause_width(NUM_IRQ, CAUSE_BASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_start,
  input  logic [31:2]        cpu_start_adr,
  input  logic               cpu_stat_pc,
  input  logic               csr_rmie,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               g_exception,
  input  logic               ecall_condition_ex,
  input  logic               jmp_condition_ex,
  input  logic               cmd_ecall_ex,
  input  logic               cmd_ebreak_ex,
  input  logic               cmd_mret_ex,
  input  logic               cmd_sret_ex,
  input  logic [31:2]        jmp_adr_ex,
  input  logic [31:2]        csr_mtvec_ex,
  input  logic [31:2]        csr_mepc_ex,
  input  logic [31:2]        csr_sepc_ex,
  input  logic               csr_mtvec_mode,
  output logic [31:2]        pc,
  output logic [31:2]        pc_excep,
  output logic [31:2]        pc_ebreak,
  output logic               cmd_ecall_pc,
  output logic               cmd_ebreak_pc,
  output logic               interrupts_in_pc_state,
  output logic               irq_taken,
  output logic [CW-1:0]      irq_cause,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam int SW = idx_width(NUM_IRQ);

  logic               any_s;
  logic [SW-1:0]      sel_s;
  logic [NUM_IRQ-1:0] pending_s;
  logic               take_s;

  logic [29:0]        pc_r;
  logic [29:0]        pc_inc_s;
  logic [29:0]        irq_tgt_s;
  logic [29:0]        pc_nxt_s;
  logic [29:0]        pc_excep_s;
  pc_src_e            pc_src_s;

  logic               start_r;
  logic               ecall_keep_r;
  logic               ebreak_keep_r;
  logic               irq_taken_r;
  logic [CW-1:0]      irq_cause_r;

  irq_pend_prio #(
    .NUM_IRQ (NUM_IRQ),
    .SW      (SW)
  ) u_irq_pend_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .irq_en  (irq_en),
    .rmie    (csr_rmie),
    .take    (take_s),
    .any     (any_s),
    .sel     (sel_s),
    .pending (pending_s)
  );

  assign take_s   = cpu_stat_pc & csr_rmie & any_s;
  assign pc_inc_s = pc_r + 30'd1;

  // Interrupt target: mtvec base, or base plus cause in vectored mode (30-bit wrap)
  always_comb begin
    irq_tgt_s = csr_mtvec_ex;
    case (csr_mtvec_mode)
      MTVEC_DIRECT:   irq_tgt_s = csr_mtvec_ex;
      MTVEC_VECTORED: irq_tgt_s = csr_mtvec_ex + 30'(CAUSE_BASE) + 30'(sel_s);
      default:        irq_tgt_s = csr_mtvec_ex;
    endcase
  end

  // Pick the PC source for this cycle in redirect priority order
  always_comb begin
    pc_src_s = PC_HOLD;
    if (!cpu_stat_pc) begin
      pc_src_s = PC_HOLD;
    end else if (start_r) begin
      pc_src_s = PC_START;
    end else if (take_s) begin
      pc_src_s = PC_IRQ;
    end else if (g_exception | ecall_condition_ex) begin
      pc_src_s = PC_TRAP;
    end else if (cmd_mret_ex) begin
      pc_src_s = PC_MRET;
    end else if (cmd_sret_ex) begin
      pc_src_s = PC_SRET;
    end else if (jmp_condition_ex) begin
      pc_src_s = PC_JMP;
    end else begin
      pc_src_s = PC_SEQ;
    end
  end

  // Map the chosen source onto the next PC value
  always_comb begin
    pc_nxt_s = pc_r;
    case (pc_src_s)
      PC_HOLD:  pc_nxt_s = pc_r;
      PC_START: pc_nxt_s = cpu_start_adr;
      PC_IRQ:   pc_nxt_s = irq_tgt_s;
      PC_TRAP:  pc_nxt_s = csr_mtvec_ex;
      PC_MRET:  pc_nxt_s = csr_mepc_ex;
      PC_SRET:  pc_nxt_s = csr_sepc_ex;
      PC_JMP:   pc_nxt_s = jmp_adr_ex;
      PC_SEQ:   pc_nxt_s = pc_inc_s;
      default:  pc_nxt_s = pc_r;
    endcase
  end

  // Return address to be saved into mepc for the instruction in EX
  always_comb begin
    pc_excep_s = pc_inc_s;
    if (g_exception | ecall_condition_ex) begin
      pc_excep_s = pc_r;
    end else if (jmp_condition_ex) begin
      pc_excep_s = jmp_adr_ex;
    end else begin
      pc_excep_s = pc_inc_s;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_nxt_s;
    end
  end

  // Start-load flag and ecall/ebreak keepers: set by request, cleared by the PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r       <= 1'b0;
      ecall_keep_r  <= 1'b0;
      ebreak_keep_r <= 1'b0;
    end else if (cpu_stat_pc) begin
      start_r       <= 1'b0;
      ecall_keep_r  <= 1'b0;
      ebreak_keep_r <= 1'b0;
    end else begin
      start_r       <= start_r | cpu_start;
      ecall_keep_r  <= ecall_keep_r | cmd_ecall_ex;
      ebreak_keep_r <= ebreak_keep_r | cmd_ebreak_ex;
    end
  end

  // Taken pulse and sticky cause of the most recent interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_taken_r <= 1'b0;
      irq_cause_r <= '0;
    end else begin
      irq_taken_r <= take_s;
      if (take_s) begin
        irq_cause_r <= CW'(CAUSE_BASE) + CW'(sel_s);
      end else begin
        irq_cause_r <= irq_cause_r;
      end
    end
  end

  assign pc                     = pc_r;
  assign pc_ebreak              = pc_r;
  assign pc_excep               = pc_excep_s;
  assign interrupts_in_pc_state = take_s;
  assign cmd_ecall_pc           = cpu_stat_pc & ecall_keep_r & ~take_s & csr_rmie;
  assign cmd_ebreak_pc          = cpu_stat_pc & ebreak_keep_r & ~take_s & csr_rmie;
  assign irq_taken              = irq_taken_r;
  assign irq_cause              = irq_cause_r;
  assign irq_pending            = pending_s;

endmodule

// File: tb/tb_pc_stage_vec.sv
// Self-checking bench for pc_stage_vec: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the PC stage.
module tb_pc_stage_vec;

  localparam int N  = 4;
  localparam int CB = 16;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          cpu_start;
  logic [31:2]   cpu_start_adr;
  logic          cpu_stat_pc;
  logic          csr_rmie;
  logic [N-1:0]  irq_in;
  logic [N-1:0]  irq_en;
  logic          g_exception;
  logic          ecall_condition_ex;
  logic          jmp_condition_ex;
  logic          cmd_ecall_ex;
  logic          cmd_ebreak_ex;
  logic          cmd_mret_ex;
  logic          cmd_sret_ex;
  logic [31:2]   jmp_adr_ex;
  logic [31:2]   csr_mtvec_ex;
  logic [31:2]   csr_mepc_ex;
  logic [31:2]   csr_sepc_ex;
  logic          csr_mtvec_mode;
  logic [31:2]   pc;
  logic [31:2]   pc_excep;
  logic [31:2]   pc_ebreak;
  logic          cmd_ecall_pc;
  logic          cmd_ebreak_pc;
  logic          interrupts_in_pc_state;
  logic          irq_taken;
  logic [CW-1:0] irq_cause;
  logic [N-1:0]  irq_pending;

  int total;
  int bad;

  pc_stage_vec #(.NUM_IRQ(N), .CAUSE_BASE(CB), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .cpu_start_adr(cpu_start_adr),
    .cpu_stat_pc(cpu_stat_pc), .csr_rmie(csr_rmie), .irq_in(irq_in), .irq_en(irq_en),
    .g_exception(g_exception), .ecall_condition_ex(ecall_condition_ex),
    .jmp_condition_ex(jmp_condition_ex), .cmd_ecall_ex(cmd_ecall_ex),
    .cmd_ebreak_ex(cmd_ebreak_ex), .cmd_mret_ex(cmd_mret_ex), .cmd_sret_ex(cmd_sret_ex),
    .jmp_adr_ex(jmp_adr_ex), .csr_mtvec_ex(csr_mtvec_ex), .csr_mepc_ex(csr_mepc_ex),
    .csr_sepc_ex(csr_sepc_ex), .csr_mtvec_mode(csr_mtvec_mode), .pc(pc),
    .pc_excep(pc_excep), .pc_ebreak(pc_ebreak), .cmd_ecall_pc(cmd_ecall_pc),
    .cmd_ebreak_pc(cmd_ebreak_pc), .interrupts_in_pc_state(interrupts_in_pc_state),
    .irq_taken(irq_taken), .irq_cause(irq_cause), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [29:0]  m_pc;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_prev;
  logic         m_start, m_ke, m_kb, m_taken;
  int           m_cause;
  logic         e_take;
  int           e_sel;
  logic [29:0]  e_tgt, e_excep;
  logic         e_ecall, e_ebreak;

  task automatic model_reset();
    m_pc = '0; m_pend = '0; m_prev = '0;
    m_start = 1'b0; m_ke = 1'b0; m_kb = 1'b0; m_taken = 1'b0; m_cause = 0;
  endtask

  task automatic model_eval();
    logic has;
    has = 1'b0;
    e_sel = 0;
    for (int i = 0; i < N; i++) begin
      if (!has && m_pend[i] && irq_en[i]) begin
        has = 1'b1;
        e_sel = i;
      end
    end
    e_take   = cpu_stat_pc && csr_rmie && has;
    e_tgt    = csr_mtvec_mode ? 30'(csr_mtvec_ex + CB + e_sel) : csr_mtvec_ex;
    e_excep  = (g_exception || ecall_condition_ex) ? m_pc :
               jmp_condition_ex ? jmp_adr_ex : 30'(m_pc + 30'd1);
    e_ecall  = cpu_stat_pc && m_ke && !e_take && csr_rmie;
    e_ebreak = cpu_stat_pc && m_kb && !e_take && csr_rmie;
  endtask

  // Advance model and DUT by one clock; returns #1 after the edge
  task automatic tick();
    logic [29:0]  n_pc;
    logic [N-1:0] n_pend;
    logic         n_start, n_ke, n_kb;
    int           n_cause;
    model_eval();
    n_pc = m_pc;
    if (cpu_stat_pc) begin
      if (m_start) n_pc = cpu_start_adr;
      else if (e_take) n_pc = e_tgt;
      else if (g_exception || ecall_condition_ex) n_pc = csr_mtvec_ex;
      else if (cmd_mret_ex) n_pc = csr_mepc_ex;
      else if (cmd_sret_ex) n_pc = csr_sepc_ex;
      else if (jmp_condition_ex) n_pc = jmp_adr_ex;
      else n_pc = 30'(m_pc + 30'd1);
    end
    for (int i = 0; i < N; i++) begin
      n_pend[i] = m_pend[i];
      if (e_take && e_sel == i) n_pend[i] = 1'b0;
      if (irq_in[i] && !m_prev[i] && irq_en[i] && csr_rmie) n_pend[i] = 1'b1;
    end
    n_start = cpu_stat_pc ? 1'b0 : (m_start || cpu_start);
    n_ke    = cpu_stat_pc ? 1'b0 : (m_ke || cmd_ecall_ex);
    n_kb    = cpu_stat_pc ? 1'b0 : (m_kb || cmd_ebreak_ex);
    n_cause = e_take ? CB + e_sel : m_cause;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pend = n_pend; m_prev = irq_in;
    m_start = n_start; m_ke = n_ke; m_kb = n_kb;
    m_taken = e_take; m_cause = n_cause;
  endtask

  task automatic idle();
    cpu_start = 1'b0; cpu_start_adr = '0; cpu_stat_pc = 1'b0; csr_rmie = 1'b1;
    irq_in = '0; irq_en = '1; g_exception = 1'b0; ecall_condition_ex = 1'b0;
    jmp_condition_ex = 1'b0; cmd_ecall_ex = 1'b0; cmd_ebreak_ex = 1'b0;
    cmd_mret_ex = 1'b0; cmd_sret_ex = 1'b0; jmp_adr_ex = '0;
    csr_mtvec_ex = 30'h100; csr_mepc_ex = 30'h200; csr_sepc_ex = 30'h300;
    csr_mtvec_mode = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    total++; if (pc !== 30'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
    total++; if (irq_pending !== 4'h0) begin bad++; $display("FAIL reset_pending: got %b want 0", irq_pending); end
    total++; if (irq_taken !== 1'b0 || irq_cause !== 5'd0) begin bad++; $display("FAIL reset_irq: got taken=%b cause=%0d want 0/0", irq_taken, irq_cause); end
    total++; if (interrupts_in_pc_state !== 1'b0 || cmd_ecall_pc !== 1'b0 || cmd_ebreak_pc !== 1'b0) begin bad++; $display("FAIL reset_comb: got %b%b%b want 000", interrupts_in_pc_state, cmd_ecall_pc, cmd_ebreak_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    idle();
    cpu_start = 1'b1; cpu_start_adr = 30'h40;
    tick();
    cpu_start = 1'b0; cpu_stat_pc = 1'b1;
    tick();
    total++; if (pc !== 30'h40) begin bad++; $display("FAIL start_pc0: got %h want 40", pc); end
    tick();
    total++; if (pc !== 30'h41) begin bad++; $display("FAIL start_pc1: got %h want 41", pc); end
    tick();
    total++; if (pc !== 30'h42) begin bad++; $display("FAIL start_pc2: got %h want 42", pc); end
    cpu_stat_pc = 1'b0;
  endtask

  task automatic test_vectored();
    idle();
    csr_mtvec_mode = 1'b1;
    irq_in[2] = 1'b1;
    tick();
    total++; if (irq_pending !== 4'b0100) begin bad++; $display("FAIL vec_pending_set: got %b want 0100", irq_pending); end
    cpu_stat_pc = 1'b1;
    #1;
    total++; if (interrupts_in_pc_state !== 1'b1) begin bad++; $display("FAIL vec_take: got %b want 1", interrupts_in_pc_state); end
    tick();
    cpu_stat_pc = 1'b0;
    total++; if (pc !== 30'h112) begin bad++; $display("FAIL vec_pc: got %h want 112", pc); end
    total++; if (irq_taken !== 1'b1 || irq_cause !== 5'd18) begin bad++; $display("FAIL vec_cause: got taken=%b cause=%0d want 1/18", irq_taken, irq_cause); end
    total++; if (irq_pending !== 4'b0000) begin bad++; $display("FAIL vec_pending_clr: got %b want 0000", irq_pending); end
    tick();
    total++; if (irq_taken !== 1'b0 || irq_cause !== 5'd18 || irq_pending !== 4'b0000) begin bad++; $display("FAIL vec_after: got taken=%b cause=%0d pend=%b want 0/18/0000", irq_taken, irq_cause, irq_pending); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_two_sources();
    idle();
    irq_in = 4'b1010;
    tick();
    cpu_stat_pc = 1'b1;
    tick();
    total++; if (pc !== 30'h100 || irq_cause !== 5'd17 || irq_pending !== 4'b1000) begin bad++; $display("FAIL two_first: got pc=%h cause=%0d pend=%b want 100/17/1000", pc, irq_cause, irq_pending); end
    tick();
    total++; if (pc !== 30'h100 || irq_cause !== 5'd19 || irq_pending !== 4'b0000) begin bad++; $display("FAIL two_second: got pc=%h cause=%0d pend=%b want 100/19/0000", pc, irq_cause, irq_pending); end
    cpu_stat_pc = 1'b0;
    irq_in = '0;
    tick();
  endtask

  task automatic test_mask();
    idle();
    irq_in[0] = 1'b1;
    tick();
    irq_en[0] = 1'b0;
    cpu_stat_pc = 1'b1;
    #1;
    total++; if (interrupts_in_pc_state !== 1'b0) begin bad++; $display("FAIL mask_take: got %b want 0", interrupts_in_pc_state); end
    tick();
    cpu_stat_pc = 1'b0;
    total++; if (irq_pending !== 4'b0001 || pc !== 30'h101 || irq_taken !== 1'b0) begin bad++; $display("FAIL mask_hold: got pend=%b pc=%h taken=%b want 0001/101/0", irq_pending, pc, irq_taken); end
    irq_en[0] = 1'b1;
    cpu_stat_pc = 1'b1;
    tick();
    cpu_stat_pc = 1'b0;
    total++; if (pc !== 30'h100 || irq_cause !== 5'd16 || irq_pending !== 4'b0000) begin bad++; $display("FAIL mask_release: got pc=%h cause=%0d pend=%b want 100/16/0000", pc, irq_cause, irq_pending); end
    csr_rmie = 1'b0;
    irq_in[3] = 1'b1;
    tick();
    tick();
    total++; if (irq_pending !== 4'b0000) begin bad++; $display("FAIL rmie_block: got %b want 0000", irq_pending); end
    idle();
    tick();
  endtask

  task automatic test_ecall_irq();
    idle();
    cpu_start = 1'b1; cpu_start_adr = 30'h20;
    tick();
    cpu_start = 1'b0; cpu_stat_pc = 1'b1;
    tick();
    cpu_stat_pc = 1'b0;
    irq_in[1] = 1'b1; cmd_ecall_ex = 1'b1;
    tick();
    cmd_ecall_ex = 1'b0;
    cpu_stat_pc = 1'b1; ecall_condition_ex = 1'b1;
    #1;
    total++; if (interrupts_in_pc_state !== 1'b1 || cmd_ecall_pc !== 1'b0) begin bad++; $display("FAIL ecall_irq_win: got take=%b ecall=%b want 1/0", interrupts_in_pc_state, cmd_ecall_pc); end
    total++; if (pc_excep !== 30'h20) begin bad++; $display("FAIL ecall_excep: got %h want 20", pc_excep); end
    tick();
    total++; if (pc !== 30'h100 || irq_cause !== 5'd17) begin bad++; $display("FAIL ecall_pc: got pc=%h cause=%0d want 100/17", pc, irq_cause); end
    cpu_stat_pc = 1'b0; ecall_condition_ex = 1'b0; cmd_ebreak_ex = 1'b1;
    tick();
    cmd_ebreak_ex = 1'b0; cpu_stat_pc = 1'b1;
    #1;
    total++; if (cmd_ebreak_pc !== 1'b1 || pc_ebreak !== 30'h100) begin bad++; $display("FAIL ebreak_keep: got kept=%b pc_ebreak=%h want 1/100", cmd_ebreak_pc, pc_ebreak); end
    tick();
    cpu_stat_pc = 1'b0;
    #1;
    total++; if (cmd_ebreak_pc !== 1'b0 || pc !== 30'h101) begin bad++; $display("FAIL ebreak_clear: got kept=%b pc=%h want 0/101", cmd_ebreak_pc, pc); end
    idle();
    tick();
  endtask

  task automatic test_jump();
    idle();
    cpu_stat_pc = 1'b1; jmp_condition_ex = 1'b1; jmp_adr_ex = 30'h80;
    #1;
    total++; if (pc_excep !== 30'h80) begin bad++; $display("FAIL jump_excep: got %h want 80", pc_excep); end
    tick();
    total++; if (pc !== 30'h80) begin bad++; $display("FAIL jump_pc: got %h want 80", pc); end
    idle();
    tick();
  endtask

  task automatic randomize_inputs();
    logic [N-1:0] flip;
    for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 3) == 0);
    irq_in             = irq_in ^ flip;
    irq_en             = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
    csr_rmie           = ($urandom_range(0, 9) != 0);
    cpu_stat_pc        = $urandom_range(0, 1);
    cpu_start          = ($urandom_range(0, 15) == 0);
    cpu_start_adr      = 30'($urandom);
    g_exception        = ($urandom_range(0, 9) == 0);
    ecall_condition_ex = ($urandom_range(0, 9) == 0);
    jmp_condition_ex   = ($urandom_range(0, 3) == 0);
    cmd_ecall_ex       = ($urandom_range(0, 7) == 0);
    cmd_ebreak_ex      = ($urandom_range(0, 7) == 0);
    cmd_mret_ex        = ($urandom_range(0, 7) == 0);
    cmd_sret_ex        = ($urandom_range(0, 7) == 0);
    jmp_adr_ex         = 30'($urandom);
    csr_mepc_ex        = 30'($urandom);
    csr_sepc_ex        = 30'($urandom);
    csr_mtvec_ex       = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFF0 | 30'($urandom_range(0, 15))) : 30'($urandom);
    csr_mtvec_mode     = $urandom_range(0, 1);
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      randomize_inputs();
      #1;
      model_eval();
      total++; if (pc !== m_pc || pc_ebreak !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d: got pc=%h ebreak=%h want %h", c, pc, pc_ebreak, m_pc); end
      total++; if (pc_excep !== e_excep) begin bad++; $display("FAIL rnd_excep c=%0d: got %h want %h", c, pc_excep, e_excep); end
      total++; if (interrupts_in_pc_state !== e_take) begin bad++; $display("FAIL rnd_take c=%0d: got %b want %b", c, interrupts_in_pc_state, e_take); end
      total++; if (cmd_ecall_pc !== e_ecall || cmd_ebreak_pc !== e_ebreak) begin bad++; $display("FAIL rnd_keep c=%0d: got %b%b want %b%b", c, cmd_ecall_pc, cmd_ebreak_pc, e_ecall, e_ebreak); end
      total++; if (irq_pending !== m_pend) begin bad++; $display("FAIL rnd_pending c=%0d: got %b want %b", c, irq_pending, m_pend); end
      total++; if (irq_taken !== m_taken || irq_cause !== CW'(m_cause)) begin bad++; $display("FAIL rnd_irq c=%0d: got %b/%0d want %b/%0d", c, irq_taken, irq_cause, m_taken, m_cause); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    randomize_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pc !== 30'h0 || irq_pending !== 4'h0 || irq_taken !== 1'b0 || irq_cause !== 5'd0) begin bad++; $display("FAIL async_reset: got pc=%h pend=%b taken=%b cause=%0d want 0", pc, irq_pending, irq_taken, irq_cause); end
    idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_start();
    test_vectored();
    test_two_sources();
    test_mask();
    test_ecall_irq();
    test_jump();
    test_random(400);
    test_async_reset();
    test_random(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
